// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-lane load/store responder with fixed response latency
// One request in flight; load data is lane-extracted and right-aligned at accept time.
module dmem_responder #(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);
  localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
  localparam logic [3:0] CNT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  accept;
  logic                  be_legal;
  logic [DM_ADDRESS-3:0] widx;
  logic [DATA_W-1:0]     lane_mask;
  logic [DATA_W-1:0]     rd_word;
  logic [DATA_W-1:0]     load_d;
  logic [4:0]            shift;
  logic                  unused_addr;

  assign widx        = req_addr[DM_ADDRESS-1:2];
  assign unused_addr = ^req_addr[1:0];
  assign req_ready   = rst_n & (state_q == IDLE);
  assign accept      = req_valid & req_ready;
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

  always_comb begin
    be_legal = 1'b0;
    case (req_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
    if (req_be[0])      shift = 5'd0;
    else if (req_be[1]) shift = 5'd8;
    else if (req_be[2]) shift = 5'd16;
    else                shift = 5'd24;
    lane_mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
    rd_word   = mem_q[widx];
    load_d    = (rd_word & lane_mask) >> shift;
  end

  // Storage has no reset: contents survive rst_n and a committed store stays committed.
  always_ff @(posedge clk) begin
    if (accept && req_we && be_legal) begin
      for (int j = 0; j < 4; j++) begin
        if (req_be[j]) mem_q[widx][8*j +: 8] <= req_wdata[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rsp_err_q   <= ~be_legal;
            rsp_rdata_q <= (!req_we && be_legal) ? load_d : '0;
            if (READ_LATENCY == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
// Inputs change and outputs are sampled on the falling edge.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .READ_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd2);
  endtask

  task automatic transact(input string tag, input logic we, input logic [8:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err);
    issue(we, addr, wdata, be);
    wait_rsp(tag);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_ready_after"}, {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    logic never_valid;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);

    transact("st_word",   1'b1, 9'h010, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    transact("ld_word",   1'b0, 9'h010, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0);
    transact("st_byte1",  1'b1, 9'h011, 32'h5A5A5A5A, 4'b0010, 32'h0, 1'b0);
    transact("ld_word2",  1'b0, 9'h010, 32'h0,        4'b1111, 32'hDEAD5AEF, 1'b0);
    transact("ld_b1",     1'b0, 9'h010, 32'h0,        4'b0010, 32'h0000005A, 1'b0);
    transact("ld_hi",     1'b0, 9'h010, 32'h0,        4'b1100, 32'h0000DEAD, 1'b0);
    transact("ld_lo",     1'b0, 9'h012, 32'h0,        4'b0011, 32'h00005AEF, 1'b0);
    transact("ld_b0",     1'b0, 9'h010, 32'h0,        4'b0001, 32'h000000EF, 1'b0);
    transact("ld_b2",     1'b0, 9'h010, 32'h0,        4'b0100, 32'h000000AD, 1'b0);
    transact("ld_b3",     1'b0, 9'h013, 32'h0,        4'b1000, 32'h000000DE, 1'b0);
    transact("st_ill",    1'b1, 9'h010, 32'hFFFFFFFF, 4'b0101, 32'h0, 1'b1);
    transact("ld_after",  1'b0, 9'h010, 32'h0,        4'b1111, 32'hDEAD5AEF, 1'b0);
    transact("ld_be0",    1'b0, 9'h010, 32'h0,        4'b0000, 32'h0, 1'b1);
    transact("ld_ill",    1'b0, 9'h010, 32'h0,        4'b1010, 32'h0, 1'b1);
    transact("st_last",   1'b1, 9'h1FC, 32'h12345678, 4'b1111, 32'h0, 1'b0);
    transact("ld_last",   1'b0, 9'h1FE, 32'h0,        4'b1100, 32'h00001234, 1'b0);
    transact("ld_noalias",1'b0, 9'h010, 32'h0,        4'b1111, 32'hDEAD5AEF, 1'b0);

    // Backpressure with a competing store that must be ignored.
    issue(1'b0, 9'h010, 32'h0, 4'b1111);
    wait_rsp("bp");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h010; req_wdata = 32'h0; req_be = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEAD5AEF);
      check("bp_err", {31'd0, rsp_err}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release", {30'd0, req_ready, rsp_valid}, 32'd2);
    transact("bp_noqueue", 1'b0, 9'h010, 32'h0, 4'b1111, 32'hDEAD5AEF, 1'b0);

    // Reset during WAIT after a store: response dropped, store kept.
    issue(1'b1, 9'h020, 32'hAABBCCDD, 4'b1111);
    check("wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("wrst_state", {29'd0, rsp_valid, busy, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    never_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) never_valid = 1'b0;
    end
    check("wrst_no_rsp", {31'd0, never_valid}, 32'd1);
    transact("wrst_ld", 1'b0, 9'h020, 32'h0, 4'b1111, 32'hAABBCCDD, 1'b0);

    // Reset during RESP: rsp_valid falls without a clock edge.
    issue(1'b0, 9'h010, 32'h0, 4'b1111);
    wait_rsp("rrst");
    #2;
    rst_n = 1'b0;
    #1;
    check("rrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rrst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    transact("rrst_ld", 1'b0, 9'h010, 32'h0, 4'b0011, 32'h00005AEF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the data path: accepts byte-lane load/store requests over a valid/ready handshake and services them against an internal word-organised array. It returns one response per request after a fixed, parameterised latency. Read data is lane-extracted and right-aligned, so the requesting load unit only performs sign or zero extension. The block sits between the core's load/store wrapper and the data storage and replaces the single-cycle memory model where multi-cycle memory timing must be exercised.

## Interface
- DM_ADDRESS, 9, byte-address width; array depth is 2^(DM_ADDRESS-2) words
- DATA_W, 32, data width; fixed at 32, giving 4 byte lanes
- READ_LATENCY, 2, cycles from request accept to first rsp_valid; legal range 1..15
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; 1 only in IDLE and only while rst_n=1
- req_we  in  1  1=store, 0=load
- req_addr  in  DM_ADDRESS  byte address; word index = req_addr[DM_ADDRESS-1:2]; bits [1:0] ignored (lanes come from req_be)
- req_wdata  in  DATA_W  lane-aligned store data; byte j is taken from bits [8j+7:8j]
- req_be  in  4  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes the response
- rsp_rdata  out  DATA_W  load result, right-aligned; 0 for stores and errors
- rsp_err  out  1  illegal byte-enable pattern
- busy  out  1  1 in WAIT or RESP

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE → accept on req_valid & req_ready.
  - If READ_LATENCY=1, go to RESP.
  - Otherwise go to WAIT with cnt=READ_LATENCY-2.
- WAIT: decrement cnt each cycle; go to RESP when cnt=0.
- RESP: hold rsp_valid=1; on rsp_ready go to IDLE.
- Legal req_be patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other value, including 0000, sets rsp_err=1, performs no write and returns rsp_rdata=0.
- Store, legal be: at the accept edge, write each enabled byte j from req_wdata[8j+7:8j]. Other bytes are untouched. Response has rsp_rdata=0, rsp_err=0.
- Load, legal be: at the accept edge, capture (word AND lane mask) >> (8 × index of lowest set be bit) into the response register. This register is held unchanged until the handshake completes.
- A store followed by a load to the same word returns the updated data.
- Exactly one response per accepted request. No request is accepted while WAIT or RESP is outstanding.
- Array contents are not initialised by reset and are not changed by reset.

## Timing
- Accept edge = T. rsp_valid is first 1 in the cycle following edge T+READ_LATENCY-1. With READ_LATENCY=2 this is two cycles after the accept cycle.
- rsp_valid, rsp_rdata and rsp_err are registered and stable while rsp_valid=1 and rsp_ready=0.
- req_ready is combinational from state (and from rst_n). It rises in the cycle after the response handshake edge.
- Minimum request spacing: READ_LATENCY+1 cycles.
- Reset values: state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0 while rst_n=0.
- Reset mid-WAIT or mid-RESP: the pending response is discarded and rsp_valid falls immediately (asynchronously). A store accepted before reset remains committed.
- req_valid while busy=1 is ignored and is not queued.
- rsp_ready while rsp_valid=0 has no effect.

## Test plan
- Reset: assert rst_n=0 mid-operation → rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, req_ready=0. Release rst_n → req_ready=1 on the next cycle.
- Store addr 0x010, data 0xDEADBEEF, be 1111, then load 0x010 with be 1111 (READ_LATENCY=2) → load response 0xDEADBEEF, rsp_valid first high exactly 2 cycles after the accept cycle, rsp_err=0.
- Byte store addr 0x011, data 0x5A5A5A5A, be 0010, then:
  - load be 1111 → 0xDEAD5AEF
  - load be 0010 → 0x0000005A
  - load be 1100 → 0x0000DEAD
- Illegal be 0101 store, data 0xFFFFFFFF, to 0x010 → rsp_err=1, rsp_rdata=0. A following word load returns 0xDEAD5AEF.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP → rsp_valid=1, rsp_rdata and rsp_err unchanged, req_ready=0, a new req_valid is not accepted. On rsp_ready=1 → handshake completes, req_ready=1 next cycle.
- Reset during WAIT after a load is accepted → rsp_valid never rises for that request. After release, a new load is accepted and responds normally.
